// File: rtl/uart_tx4_if.sv
// uart_tx4_if: control, payload and serial-status signals of the four-byte UART transmitter
interface uart_tx4_if;
  logic       sample_clk;
  logic       start;
  logic [1:0] nbytes;
  logic [7:0] t1, t2, t3, t4;
  logic       parity_en;
  logic       parity_kind;
  logic       txd;
  logic       busy;
  logic       done;
  logic [1:0] byte_idx;
  modport master (
    output sample_clk, start, nbytes, t1, t2, t3, t4, parity_en, parity_kind,
    input  txd, busy, done, byte_idx
  );
  modport slave (
    input  sample_clk, start, nbytes, t1, t2, t3, t4, parity_en, parity_kind,
    output txd, busy, done, byte_idx
  );
endinterface

// File: rtl/uart_tx4.sv
// uart_tx4: serialises a burst of up to four bytes as LSB-first UART frames with optional parity
module uart_tx4 #(
  parameter int TICKS_PER_BIT = 8,
  parameter int GAP_BITS      = 1
) (
  input logic      clk,
  input logic      rst_n,
  uart_tx4_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
  state_t          state_q;
  logic [3:0]      tick_q;
  logic [2:0]      bit_q;
  logic [1:0]      gap_q;
  logic [3:0][7:0] data_q;
  logic [1:0]      nbytes_q;
  logic            par_en_q, par_kind_q;
  logic            txd_q, busy_q, done_q;
  logic [1:0]      idx_q;
  logic [7:0]      cur;
  logic            bit_end;
  assign cur          = data_q[idx_q];
  assign bit_end      = bus.sample_clk && (tick_q == 4'(TICKS_PER_BIT - 1));
  assign bus.txd      = txd_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.byte_idx = idx_q;
  // Frame sequencer: accepts a burst in IDLE, then advances one bit per TICKS_PER_BIT sample pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      data_q     <= '0;
      nbytes_q   <= '0;
      par_en_q   <= 1'b0;
      par_kind_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.start) begin
          data_q     <= {bus.t4, bus.t3, bus.t2, bus.t1};
          nbytes_q   <= bus.nbytes;
          par_en_q   <= bus.parity_en;
          par_kind_q <= bus.parity_kind;
          busy_q     <= 1'b1;
          idx_q      <= '0;
          txd_q      <= 1'b0;
          tick_q     <= '0;
          state_q    <= START;
        end
      end else if (bit_end) begin
        tick_q <= '0;
        case (state_q)
          START: begin
            bit_q   <= '0;
            txd_q   <= cur[0];
            state_q <= DATA;
          end
          DATA: begin
            if (bit_q == 3'd7) begin
              txd_q   <= par_en_q ? (^cur ^ par_kind_q) : 1'b1;
              state_q <= par_en_q ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= cur[bit_q + 3'd1];
            end
          end
          PARITY: begin
            txd_q   <= 1'b1;
            state_q <= STOP;
          end
          STOP: begin
            if (idx_q == nbytes_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + 2'd1;
              gap_q   <= '0;
              txd_q   <= (GAP_BITS == 0) ? 1'b0 : 1'b1;
              state_q <= (GAP_BITS == 0) ? START : GAP;
            end
          end
          GAP: begin
            if (gap_q == 2'(GAP_BITS - 1)) begin
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              gap_q <= gap_q + 2'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (bus.sample_clk) begin
        tick_q <= tick_q + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx4.sv
// tb_uart_tx4: directed checks of framing, parity, bursts, busy protection, reset and stalls
module tb_uart_tx4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic [1:0] div = 2'd0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dones = 0;
  uart_tx4_if bus ();
  uart_tx4 #(.TICKS_PER_BIT(8), .GAP_BITS(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // sample_clk every 4 clk; stall freezes the divider so pulses resume exactly where they stopped
  always @(negedge clk) begin
    if (!stall) div++;
    bus.sample_clk = (div == 2'd3) && !stall;
    if (bus.done === 1'b1) dones++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic go(input logic [1:0] nb, input logic [7:0] a, b, c, d, input logic pe, pk);
    bus.nbytes = nb; bus.t1 = a; bus.t2 = b; bus.t3 = c; bus.t4 = d;
    bus.parity_en = pe; bus.parity_kind = pk; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_on_accept", bus.busy, 1);
  endtask
  task automatic wait_level(input logic lvl, output int t);
    int n = 0;
    while (bus.txd !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("txd_timeout", 0, 1);
    t = cyc;
  endtask
  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("done_timeout", 0, 1);
  endtask
  task automatic rx_frame(input bit par, input int poke, output logic [7:0] d, output logic p, output int t);
    wait_level(1'b0, t);
    repeat (15) @(negedge clk);
    chk("start_bit", bus.txd, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (31) @(negedge clk);
      if (i == poke) begin
        bus.start = 1'b1;
        bus.t1 = 8'hFF;
      end
      @(negedge clk);
      bus.start = 1'b0;
      d[i] = bus.txd;
    end
    p = 1'b0;
    if (par) begin
      repeat (32) @(negedge clk);
      p = bus.txd;
    end
    repeat (32) @(negedge clk);
    chk("stop_bit", bus.txd, 1);
  endtask
  logic [7:0] d;
  logic p;
  int t, ta, tb, d0;
  int ts[4];
  logic [7:0] pt[3] = '{8'h03, 8'h07, 8'h03};
  logic pk[3] = '{1'b1, 1'b0, 1'b0};
  logic pe[3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] bv[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  initial begin
    bus.start = 1'b0; bus.nbytes = 2'd0; bus.t1 = '0; bus.t2 = '0; bus.t3 = '0; bus.t4 = '0;
    bus.parity_en = 1'b0; bus.parity_kind = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", bus.txd, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_idx", bus.byte_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    go(2'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    rx_frame(1'b0, -1, d, p, t);
    chk("single_a5", d, 8'hA5);
    wait_done();
    chk("single_busy_off", bus.busy, 0);
    chk("single_txd_idle", bus.txd, 1);
    @(negedge clk);
    chk("single_done_pulse", bus.done, 0);
    for (int k = 0; k < 3; k++) begin
      go(2'd0, pt[k], 8'h00, 8'h00, 8'h00, 1'b1, pk[k]);
      rx_frame(1'b1, -1, d, p, t);
      chk("par_data", d, pt[k]);
      chk("par_bit", p, pe[k]);
      wait_done();
      @(negedge clk);
    end
    d0 = dones;
    go(2'd3, bv[0], bv[1], bv[2], bv[3], 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rx_frame(1'b0, -1, d, p, ts[k]);
      chk("burst_data", d, bv[k]);
      chk("burst_idx", bus.byte_idx, k);
    end
    wait_done();
    repeat (3) @(negedge clk);
    chk("burst_one_done", dones - d0, 1);
    chk("burst_gap_23", ts[2] - ts[1], 352);
    chk("burst_gap_34", ts[3] - ts[2], 352);
    go(2'd0, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    rx_frame(1'b0, 2, d, p, t);
    chk("busy_ignore_data", d, 8'h5A);
    wait_done();
    repeat (40) @(negedge clk);
    chk("busy_no_second", bus.busy, 0);
    go(2'd0, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_done();
    bus.t1 = 8'hC3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_after_done", bus.busy, 1);
    rx_frame(1'b0, -1, d, p, t);
    chk("restart_data", d, 8'hC3);
    wait_done();
    @(negedge clk);
    go(2'd1, 8'h81, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    rx_frame(1'b0, -1, d, p, t);
    chk("rst_frame1", d, 8'h81);
    wait_level(1'b0, t);
    repeat (15 + 32 * 5) @(negedge clk);
    chk("pre_rst_txd", bus.txd, 0);
    chk("pre_rst_idx", bus.byte_idx, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_txd", bus.txd, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_idx", bus.byte_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    go(2'd0, 8'h96, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    rx_frame(1'b0, -1, d, p, t);
    chk("post_rst_data", d, 8'h96);
    wait_done();
    @(negedge clk);
    go(2'd0, 8'h03, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_level(1'b1, ta);
    repeat (256 + 15) @(negedge clk);
    chk("stall_par_pre", bus.txd, 0);
    @(posedge clk) stall = 1'b1;
    repeat (50) @(negedge clk);
    chk("stall_par_hold", bus.txd, 0);
    chk("stall_busy", bus.busy, 1);
    @(posedge clk) stall = 1'b0;
    @(negedge clk);
    wait_level(1'b1, tb);
    chk("stall_timing", tb - ta, 338);
    wait_done();
    chk("stall_done_idle", bus.txd, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
